uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DBIT, default 8: data width in bits; matches the receiver's dout width.
REQ-002 Parameter ADDR_W, default 4: address width; depth = 2**ADDR_W entries (16).
REQ-003 clk  input  1  single clock; all state is updated on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx_done_tick  input  1  one-cycle push strobe from the UART receiver.
REQ-006 din  input  DBIT  received data; valid only while rx_done_tick is 1.
REQ-007 e_parity_in  input  1  parity-error flag for din; captured with it.
REQ-008 e_frame_in  input  1  framing-error flag for din; captured with it.
REQ-009 rd  input  1  pop strobe; pops the head entry on the clock edge when not empty.
REQ-010 clr  input  1  synchronous flush strobe.
REQ-011 rd_data  output  DBIT  head entry data (first-word fall-through).
REQ-012 rd_e_parity  output  1  parity-error flag of the head entry.
REQ-013 rd_e_frame  output  1  framing-error flag of the head entry.
REQ-014 empty  output  1  1 when level = 0.
REQ-015 full  output  1  1 when level = 2**ADDR_W.
REQ-016 level  output  ADDR_W+1  number of stored entries, 0..2**ADDR_W.
REQ-017 overrun  output  1  sticky flag; set when a push is dropped.

Function
REQ-018 Each entry SHALL be {e_frame_in, e_parity_in, din}, DBIT+2 bits wide.
REQ-019 Push SHALL occur when rx_done_tick=1 and (full=0 or a pop is accepted in the same cycle); the entry is written at the write pointer, which then increments.
REQ-020 Pop SHALL occur when rd=1 and empty=0; the read pointer then increments.
REQ-021 rd/rd_e_parity/rd_e_frame SHALL present the head entry combinationally from storage; contents are don't-care while empty=1.
REQ-022 Latency: a push into an empty FIFO SHALL make empty=0 and show the entry on rd_data in the cycle after the push edge.
REQ-023 Pointers SHALL be ADDR_W+1 bits and wrap modulo 2**(ADDR_W+1); level = wr_ptr - rd_ptr (modular).
REQ-024 Simultaneous push and pop SHALL both be performed and leave level unchanged, including when full (no overrun) or empty (pop ignored, push proceeds, level becomes 1).
REQ-025 rx_done_tick while full with no accepted pop SHALL discard the data, leave the storage unchanged, and set overrun=1 on that edge.
REQ-026 rd while empty SHALL be ignored, with no state change and no error flag.
REQ-027 clr=1 SHALL zero both pointers and clear overrun, and SHALL take priority over any push or pop in the same cycle (the incoming byte is discarded and overrun is not set).
REQ-028 overrun SHALL remain 1 until clr or reset.
REQ-029 Storage contents SHALL NOT be required to reset; only pointers and flags.

Reset
REQ-030 While reset=0: pointers=0, overrun=0, empty=1, full=0, level=0; clearing occurs immediately and asynchronously, independent of clk.
REQ-031 Reset asserted mid-operation SHALL discard all entries; the first push after release SHALL be stored at address 0.

Structure
REQ-032 Shared package uart_pkg SHALL hold the entry-width function DBIT+2, the default ADDR_W, and the entry field positions (data, parity, frame).
REQ-033 Sub-module fifo_ctrl SHALL own the pointers, level/full/empty and push/pop qualification; uart_rx_fifo SHALL instantiate it beside the register-file storage.

Verification
REQ-034 Push 0x41, 0x42, 0x43 with flags 0 -> level=3; three pops return 0x41, 0x42, 0x43 in order; empty=1 after the last pop.
REQ-035 Push 16 bytes 0x00..0x0F, then push 0xAA -> full=1, overrun=1, level=16; draining returns 0x00..0x0F and never 0xAA.
REQ-036 While full, rx_done_tick and rd together with din=0x55 -> 0x00 popped, level stays 16, overrun stays 0; the last entry drained is 0x55.
REQ-037 Push 0x7E with e_parity_in=1, e_frame_in=0, then 0x0D with e_frame_in=1 -> rd_e_parity=1 on the first head, rd_e_frame=1 on the second.
REQ-038 Run 40 push/pop pairs to wrap the pointers, then assert clr together with rx_done_tick -> level=0, empty=1, overrun=0; the byte is not stored.
REQ-039 Assert reset asynchronously (between clk edges) with 5 entries stored -> empty=1 and level=0 without waiting for a clock edge; the next push appears on rd_data.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and entry-layout helpers for the UART receive FIFO.
// An entry is {frame_err, parity_err, data}.
package uart_pkg;

   localparam int DBIT_DEF   = 8;
   localparam int ADDR_W_DEF = 4;
   localparam int DATA_LSB   = 0;

   function automatic int entry_w(input int dbit);
      return dbit + 2;
   endfunction

   function automatic int parity_pos(input int dbit);
      return dbit;
   endfunction

   function automatic int frame_pos(input int dbit);
      return dbit + 1;
   endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Push/pop and status bundle between the UART receiver side and the FIFO.
// The master drives the strobes; the slave (the FIFO) returns head data and status.
interface uart_rx_fifo_if
   import uart_pkg::*;
#(
   parameter int DBIT   = DBIT_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) ();

   logic              rx_done_tick;
   logic [DBIT-1:0]   din;
   logic              e_parity_in;
   logic              e_frame_in;
   logic              rd;
   logic              clr;
   logic [DBIT-1:0]   rd_data;
   logic              rd_e_parity;
   logic              rd_e_frame;
   logic              empty;
   logic              full;
   logic [ADDR_W:0]   level;
   logic              overrun;

   modport master (
      output rx_done_tick, din, e_parity_in, e_frame_in, rd, clr,
      input  rd_data, rd_e_parity, rd_e_frame, empty, full, level, overrun
   );

   modport slave (
      input  rx_done_tick, din, e_parity_in, e_frame_in, rd, clr,
      output rd_data, rd_e_parity, rd_e_frame, empty, full, level, overrun
   );

endinterface

// File: rtl/uart_rx_fifo_ctrl.sv
// Pointer, level and overrun bookkeeping for the receive FIFO.
// Pointers carry one extra bit so full and empty differ without a separate count.
module fifo_ctrl
   import uart_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push_req,
   input  logic              pop_req,
   input  logic              clr,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   level,
   output logic              overrun
);

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

   logic [ADDR_W:0] wr_ptr;
   logic [ADDR_W:0] rd_ptr;
   logic            pop;
   logic            push;
   logic            drop;

   assign level   = wr_ptr - rd_ptr;
   assign empty   = (level == '0);
   assign full    = (level == DEPTH);
   assign wr_addr = wr_ptr[ADDR_W-1:0];
   assign rd_addr = rd_ptr[ADDR_W-1:0];

   // A flush wins over everything: nothing is written, popped or flagged that cycle.
   assign pop   = pop_req && !empty && !clr;
   assign push  = push_req && (!full || pop) && !clr;
   assign drop  = push_req && full && !pop && !clr;
   assign wr_en = push;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         overrun <= 1'b0;
      end else if (clr) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         overrun <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ONE;
         if (pop)  rd_ptr <= rd_ptr + ONE;
         if (drop) overrun <= 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: stores data with its parity/frame flags
// and presents the head entry first-word fall-through.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DBIT   = DBIT_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic       clk,
   input  logic       reset,
   uart_rx_fifo_if.slave bus
);

   localparam int EW    = entry_w(DBIT);
   localparam int P_POS = parity_pos(DBIT);
   localparam int F_POS = frame_pos(DBIT);

   logic [EW-1:0]     mem [2**ADDR_W];
   logic [EW-1:0]     head;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;

   fifo_ctrl #(.ADDR_W(ADDR_W)) u_ctrl (
      .clk      (clk),
      .reset    (reset),
      .push_req (bus.rx_done_tick),
      .pop_req  (bus.rd),
      .clr      (bus.clr),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .rd_addr  (rd_addr),
      .empty    (bus.empty),
      .full     (bus.full),
      .level    (bus.level),
      .overrun  (bus.overrun)
   );

   // NOTE: storage has no reset; the pointers alone decide which entries are valid,
   // and leaving the array unreset lets it map onto plain register-file cells.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= {bus.e_frame_in, bus.e_parity_in, bus.din};
   end

   assign head            = mem[rd_addr];
   assign bus.rd_data     = head[DATA_LSB +: DBIT];
   assign bus.rd_e_parity = head[P_POS];
   assign bus.rd_e_frame  = head[F_POS];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo: ordering, error flags, full/overrun,
// simultaneous push/pop, pointer wrap, flush priority and asynchronous reset.
module tb_uart_rx_fifo;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   uart_rx_fifo_if #(.DBIT(8), .ADDR_W(4)) bus ();

   uart_rx_fifo #(.DBIT(8), .ADDR_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive strobes, take one rising edge, then release them 1 time unit later.
   task automatic cycle(input logic push, input logic pop, input logic flush,
                        input logic [7:0] d, input logic p, input logic f);
      bus.rx_done_tick = push;
      bus.rd           = pop;
      bus.clr          = flush;
      bus.din          = d;
      bus.e_parity_in  = p;
      bus.e_frame_in   = f;
      @(posedge clk);
      #1;
      bus.rx_done_tick = 1'b0;
      bus.rd           = 1'b0;
      bus.clr          = 1'b0;
      bus.din          = 8'h00;
      bus.e_parity_in  = 1'b0;
      bus.e_frame_in   = 1'b0;
   endtask

   task automatic push(input logic [7:0] d);
      cycle(1'b1, 1'b0, 1'b0, d, 1'b0, 1'b0);
   endtask

   task automatic pop();
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      bus.rx_done_tick = 1'b0;
      bus.rd           = 1'b0;
      bus.clr          = 1'b0;
      bus.din          = 8'h00;
      bus.e_parity_in  = 1'b0;
      bus.e_frame_in   = 1'b0;

      // Reset state
      #12;
      check("rst_empty", 32'(bus.empty), 32'd1);
      check("rst_full", 32'(bus.full), 32'd0);
      check("rst_level", 32'(bus.level), 32'd0);
      check("rst_overrun", 32'(bus.overrun), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // In-order push/pop with fall-through latency
      push(8'h41);
      check("ff_empty", 32'(bus.empty), 32'd0);
      check("ff_data", 32'(bus.rd_data), 32'h41);
      push(8'h42);
      push(8'h43);
      check("ord_level", 32'(bus.level), 32'd3);
      pop();
      check("ord_pop2", 32'(bus.rd_data), 32'h42);
      pop();
      check("ord_pop3", 32'(bus.rd_data), 32'h43);
      pop();
      check("ord_empty", 32'(bus.empty), 32'd1);
      pop();
      check("rd_empty_level", 32'(bus.level), 32'd0);
      check("rd_empty_ovr", 32'(bus.overrun), 32'd0);

      // Error flags travel with their byte
      cycle(1'b1, 1'b0, 1'b0, 8'h7E, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 8'h0D, 1'b0, 1'b1);
      check("flag_d1", 32'(bus.rd_data), 32'h7E);
      check("flag_p1", 32'(bus.rd_e_parity), 32'd1);
      check("flag_f1", 32'(bus.rd_e_frame), 32'd0);
      pop();
      check("flag_d2", 32'(bus.rd_data), 32'h0D);
      check("flag_p2", 32'(bus.rd_e_parity), 32'd0);
      check("flag_f2", 32'(bus.rd_e_frame), 32'd1);
      pop();
      check("flag_empty", 32'(bus.empty), 32'd1);

      // Fill, overrun on the 17th push, drain without the dropped byte
      for (int i = 0; i < 16; i++) push(8'(i));
      check("fill_full", 32'(bus.full), 32'd1);
      check("fill_level", 32'(bus.level), 32'd16);
      check("fill_ovr", 32'(bus.overrun), 32'd0);
      push(8'hAA);
      check("ovr_set", 32'(bus.overrun), 32'd1);
      check("ovr_level", 32'(bus.level), 32'd16);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("drain1_%0d", i), 32'(bus.rd_data), 32'(i));
         pop();
      end
      check("drain1_empty", 32'(bus.empty), 32'd1);
      check("ovr_sticky", 32'(bus.overrun), 32'd1);
      cycle(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      check("clr_ovr", 32'(bus.overrun), 32'd0);

      // Push and pop together while full
      for (int i = 0; i < 16; i++) push(8'(i));
      cycle(1'b1, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
      check("fpp_level", 32'(bus.level), 32'd16);
      check("fpp_ovr", 32'(bus.overrun), 32'd0);
      check("fpp_head", 32'(bus.rd_data), 32'h01);
      for (int i = 1; i < 16; i++) begin
         check($sformatf("drain2_%0d", i), 32'(bus.rd_data), 32'(i));
         pop();
      end
      check("drain2_last", 32'(bus.rd_data), 32'h55);
      pop();
      check("drain2_empty", 32'(bus.empty), 32'd1);

      // Push and pop together while empty: only the push happens
      cycle(1'b1, 1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
      check("epp_level", 32'(bus.level), 32'd1);
      check("epp_data", 32'(bus.rd_data), 32'h99);

      // 40 simultaneous pairs wrap both pointers; head tracks the previous byte
      for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b0, 8'(8'h80 + i), 1'b0, 1'b0);
      check("wrap_level", 32'(bus.level), 32'd1);
      check("wrap_head", 32'(bus.rd_data), 32'hA7);
      cycle(1'b1, 1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
      check("clr_level", 32'(bus.level), 32'd0);
      check("clr_empty", 32'(bus.empty), 32'd1);
      check("clr_ovr2", 32'(bus.overrun), 32'd0);
      push(8'h33);
      check("post_clr_level", 32'(bus.level), 32'd1);
      check("post_clr_data", 32'(bus.rd_data), 32'h33);
      pop();

      // Asynchronous reset between edges with 5 entries stored
      for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
      check("pre_rst_level", 32'(bus.level), 32'd5);
      #2;
      reset = 1'b0;
      #1;
      check("arst_empty", 32'(bus.empty), 32'd1);
      check("arst_level", 32'(bus.level), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      push(8'hC3);
      check("post_rst_data", 32'(bus.rd_data), 32'hC3);
      check("post_rst_level", 32'(bus.level), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
